// File: rtl/fpcvt_pkg.sv
// Shared definitions for the FPCVT linear-to-float encoder: state encoding and
// the parameter derivation helpers used by fpcvt_seq and fpcvt_round.
package fpcvt_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Left shifts available before the mantissa window reaches the LSB.
  function automatic int shift_max(input int in_w, input int man_w);
    return in_w - man_w;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fpcvt_round.sv
// Combinational round/saturate stage of the FPCVT encoder.
// Build option FPCVT_RNE_EN selects round-to-nearest-even; the default is round half up.
module fpcvt_round
  import fpcvt_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic [MAN_W-1:0] m,
  input  logic             r,
  input  logic             s,
  input  logic [EXP_W:0]   e,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] man,
  output logic             ovf
);

  localparam logic [EXP_W:0] E_LIM = (EXP_W+1)'(exp_max(EXP_W));

  logic up;

`ifdef FPCVT_RNE_EN
  assign up = r & (s | m[0]);
`else
  logic unused_s;
  assign unused_s = s;
  assign up       = r;
`endif

  always_comb begin
    exp = e[EXP_W-1:0];
    man = m;
    ovf = 1'b0;
    if (e > E_LIM) begin
      exp = '1;
      man = '1;
      ovf = 1'b1;
    end else if (up && (&m)) begin
      // Mantissa carry-out renormalises into the exponent, unless that overflows too.
      if (e == E_LIM) begin
        exp = '1;
        man = '1;
        ovf = 1'b1;
      end else begin
        man            = '0;
        man[MAN_W-1]   = 1'b1;
        exp            = e[EXP_W-1:0] + EXP_W'(1);
      end
    end else if (up) begin
      man = m + MAN_W'(1);
    end
  end

endmodule

// File: rtl/fpcvt_seq.sv
// Sequential linear-to-float encoder: abs, iterative one-bit normalise, round, saturate,
// with valid/ready on both sides. Build option FPCVT_RNE_EN enables round-to-nearest-even.
module fpcvt_seq
  import fpcvt_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_ovf
);

  localparam int SHIFT_MAX = shift_max(IN_W, MAN_W);
  localparam int EXP_MAX   = exp_max(EXP_W);
  localparam int LZ_W      = $clog2(SHIFT_MAX + 1);
  localparam logic [LZ_W-1:0] LZ_LAST = LZ_W'(SHIFT_MAX);

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [IN_W-1:0]  mag_q, mag_d;
  logic [LZ_W-1:0]  lz_q, lz_d;
  logic             out_sign_q, out_sign_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [MAN_W-1:0] out_man_q, out_man_d;
  logic             out_ovf_q, out_ovf_d;

  logic             norm_done;
  logic [MAN_W-1:0] rnd_m;
  logic             rnd_r, sticky;
  logic [31:0]      e_full;
  logic [EXP_W:0]   e_rnd;
  logic [EXP_W-1:0] rnd_exp;
  logic [MAN_W-1:0] rnd_man;
  logic             rnd_ovf;

  assign norm_done = mag_q[IN_W-1] | (lz_q == LZ_LAST);
  assign rnd_m     = mag_q[IN_W-1 -: MAN_W];

  if (SHIFT_MAX > 0) begin : g_rbit
    assign rnd_r = mag_q[IN_W-1-MAN_W];
  end else begin : g_nor
    assign rnd_r = 1'b0;
  end

`ifdef FPCVT_RNE_EN
  if (IN_W - 2 - MAN_W >= 0) begin : g_sticky
    assign sticky = |mag_q[IN_W-2-MAN_W:0];
  end else begin : g_nosticky
    assign sticky = 1'b0;
  end
`else
  assign sticky = 1'b0;
`endif

  // Exponent is clamped to EXP_MAX+1 so any out-of-range value still reads as overflow.
  always_comb begin
    e_full = 32'(SHIFT_MAX) - 32'(lz_q);
    e_rnd  = (e_full > 32'(EXP_MAX)) ? (EXP_W+1)'(EXP_MAX + 1) : e_full[EXP_W:0];
  end

  fpcvt_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .m   (rnd_m),
    .r   (rnd_r),
    .s   (sticky),
    .e   (e_rnd),
    .exp (rnd_exp),
    .man (rnd_man),
    .ovf (rnd_ovf)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_NORM;
      ST_NORM:  if (norm_done) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    sign_d     = sign_q;
    mag_d      = mag_q;
    lz_d       = lz_q;
    out_sign_d = out_sign_q;
    out_exp_d  = out_exp_q;
    out_man_d  = out_man_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        sign_d = in_data[IN_W-1];
        // The most negative code maps to 2^(IN_W-1), which fits unsigned.
        mag_d  = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
        lz_d   = '0;
      end
      ST_NORM: if (!norm_done) begin
        mag_d = mag_q << 1;
        lz_d  = lz_q + LZ_W'(1);
      end
      ST_ROUND: begin
        out_sign_d = sign_q;
        out_exp_d  = rnd_exp;
        out_man_d  = rnd_man;
        out_ovf_d  = rnd_ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q     <= 1'b0;
      mag_q      <= '0;
      lz_q       <= '0;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_man_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      lz_q       <= lz_d;
      out_sign_q <= out_sign_d;
      out_exp_q  <= out_exp_d;
      out_man_q  <= out_man_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_sign = out_sign_q;
  assign out_exp  = out_exp_q;
  assign out_man  = out_man_q;
  assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_fpcvt_seq.sv
// Directed scoreboard bench for fpcvt_seq at default parameters (12/3/4).
module tb_fpcvt_seq;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man;
  logic             out_ovf;

  res_t obs_r;
  assign obs_r = {out_sign, out_exp, out_man, out_ovf};

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  fpcvt_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic s, input logic [EXP_W-1:0] e,
                              input logic [MAN_W-1:0] m, input logic o);
    return {s, e, m, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input res_t e);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
    chk({tag, "_lat"}, n, lat);
  endtask

  task automatic pop_cmp(input string tag);
    res_t e;
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, 32'(obs_r), 32'(e));
  endtask

  task automatic conv(input string tag, input logic [IN_W-1:0] d, input int lat, input res_t e);
    send(d, e);
    wait_out(tag, lat);
    pop_cmp(tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r422;
    r422 = mk(1'b0, 3'd5, 4'b1101, 1'b0);

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", 32'(obs_r), 0);
    rst_n = 1'b1;
    tick();

    conv("t1_422",   12'h1A6, 5,  r422);
    conv("t2_125",   12'd125, 7,  mk(1'b0, 3'd4, 4'b1000, 1'b0));
    conv("t2_m5",    12'hFFB, 10, mk(1'b1, 3'd0, 4'b0101, 1'b0));
    conv("t3_m2048", 12'h800, 2,  mk(1'b1, 3'd7, 4'b1111, 1'b1));
    conv("t3_7ff",   12'h7FF, 3,  mk(1'b0, 3'd7, 4'b1111, 1'b1));
    conv("t3_zero",  12'h000, 10, mk(1'b0, 3'd0, 4'b0000, 1'b0));
    conv("t3_one",   12'h001, 10, mk(1'b0, 3'd0, 4'b0001, 1'b0));
    conv("t3_m2047", 12'h801, 3,  mk(1'b1, 3'd7, 4'b1111, 1'b1));

    // Stall in DONE with an ignored input request
    out_ready = 1'b0;
    send(12'h1A6, r422);
    wait_out("t4_stall", 5);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 12'h123;
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_in_ready", in_ready, 0);
      chk("t4_hold_data", 32'(obs_r), 32'(r422));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pop_cmp("t4_release");
    tick();
    chk("t4_in_ready_after", in_ready, 1);
    chk("t4_valid_dropped", out_valid, 0);
    chk("t4_keep_last", 32'(obs_r), 32'(r422));
    conv("t4_b2b_125", 12'd125, 7,  mk(1'b0, 3'd4, 4'b1000, 1'b0));
    conv("t4_b2b_m5",  12'hFFB, 10, mk(1'b1, 3'd0, 4'b0101, 1'b0));

    // Reset while normalising
    in_data  = 12'h001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_outputs", 32'(obs_r), 0);
    chk("t5_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_in_ready", in_ready, 1);
    chk("t5_post_valid", out_valid, 0);
    conv("t5_after_422", 12'h1A6, 5, r422);

`ifdef FPCVT_RNE_EN
    conv("t6_tie_168", 12'd168, 6, mk(1'b0, 3'd4, 4'b1010, 1'b0));
`else
    conv("t6_tie_168", 12'd168, 6, mk(1'b0, 3'd4, 4'b1011, 1'b0));
`endif
    conv("t6_184", 12'd184, 6, mk(1'b0, 3'd4, 4'b1100, 1'b0));

    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
